mux2_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 2:1 data mux between requester A and requester B.
- Grants the mux to one requester at a time and drives the select line.
- Holds each grant for a burst of beats, then releases it.
- Registers the selected data onto a single output channel.
- Sits in front of any shared single-port sink: display bus, UART TX, memory write port.

---
 rtl/mux2_arbiter.sv | 136 +++++++++++++
 tb/tb_mux2_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter and sequencer for a shared 2:1 data mux.
// Grants the mux to requester A or B for one burst at a time, drives the
// select line and registers the selected beat onto a single output channel.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_a/data_a/last_a - requester A beat valid, data, final-beat marker
//   req_b/data_b/last_b - requester B beat valid, data, final-beat marker
//   gnt_a, gnt_b      - registered grants (never both high)
//   sel               - registered mux select, 0 = A, 1 = B (equals gnt_b)
//   out_data          - registered data of the beat transferred last cycle
//   out_valid         - out_data carries a beat transferred last cycle
module mux2_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              last_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              last_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                ptr, ptr_nxt;          // 0: A has priority, 1: B
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                beat;
  logic [DATA_W-1:0]   beat_data;
  logic                own_req;
  logic                own_last;
  logic                oth_req;
  logic                rel;

  // State register plus registered grants, select and output channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      sel       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt_a     <= (state_nxt == OWN_A);
      gnt_b     <= (state_nxt == OWN_B);
      sel       <= (state_nxt == OWN_B);
      out_valid <= beat;
      if (beat) begin
        out_data <= beat_data;
      end
    end
  end

  // Next-state, pointer, beat counter and beat detection
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    beat      = 1'b0;
    beat_data = data_a;
    rel       = 1'b0;
    own_req   = 1'b0;
    own_last  = 1'b0;
    oth_req   = 1'b0;
    cnt_inc   = cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          state_nxt = ptr ? OWN_B : OWN_A;
        end else if (req_a) begin
          state_nxt = OWN_A;
        end else if (req_b) begin
          state_nxt = OWN_B;
        end
      end

      OWN_A, OWN_B: begin
        own_req   = (state == OWN_B) ? req_b  : req_a;
        own_last  = (state == OWN_B) ? last_b : last_a;
        oth_req   = (state == OWN_B) ? req_a  : req_b;
        beat_data = (state == OWN_B) ? data_b : data_a;

        if (own_req) begin
          beat = 1'b1;
          // Counter stops one short of MAX_BURST, so it never wraps
          if (own_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            rel = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          rel = 1'b1;
        end

        // Release hands priority to the other side; no bubble if it waits
        if (rel) begin
          ptr_nxt = (state == OWN_A);
          cnt_nxt = '0;
          if (oth_req) begin
            state_nxt = (state == OWN_A) ? OWN_B : OWN_A;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter with a scoreboard of expected output beats.
module tb_mux2_arbiter;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req_a, last_a, req_b, last_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b, sel, out_valid;
  logic [DATA_W-1:0] out_data;

  int                tests  = 0;
  int                failed = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              beat_pend;
  logic              cur_ga, cur_gb;
  logic [DATA_W-1:0] last_data;

  mux2_arbiter #(.DATA_W(DATA_W), .MAX_BURST(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .data_a   (data_a),
    .last_a   (last_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .last_b   (last_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt_a"},     32'(gnt_a),     32'd0);
    chk({tag, ".gnt_b"},     32'(gnt_b),     32'd0);
    chk({tag, ".sel"},       32'(sel),       32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
  endtask

  // Drive one cycle of inputs; a beat is expected wherever the bench's own
  // expected grant meets a request
  task automatic drive(input logic ra, input logic [DATA_W-1:0] da, input logic la,
                       input logic rb, input logic [DATA_W-1:0] db, input logic lb);
    req_a = ra; data_a = da; last_a = la;
    req_b = rb; data_b = db; last_b = lb;
    beat_pend = 1'b0;
    if (cur_ga && ra) begin
      exp_q.push_back(da);
      beat_pend = 1'b1;
    end
    if (cur_gb && rb) begin
      exp_q.push_back(db);
      beat_pend = 1'b1;
    end
  endtask

  // Advance one clock and check grants and output channel
  task automatic cyc(input string tag, input logic ega, input logic egb);
    logic [DATA_W-1:0] e;
    @(posedge clk); #1;
    chk({tag, ".gnt_a"},     32'(gnt_a),         32'(ega));
    chk({tag, ".gnt_b"},     32'(gnt_b),         32'(egb));
    chk({tag, ".sel"},       32'(sel),           32'(egb));
    chk({tag, ".overlap"},   32'(gnt_a & gnt_b), 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid),     32'(beat_pend));
    if (beat_pend) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".out_data"}, 32'(out_data), 32'(e));
        last_data = e;
      end
    end else begin
      chk({tag, ".hold"}, 32'(out_data), 32'(last_data));
    end
    cur_ga = ega;
    cur_gb = egb;
  endtask

  task automatic idle_in();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Three cycles of reset with random inputs, then release
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'($urandom); data_a = 8'($urandom); last_a = 1'($urandom);
      req_b = 1'($urandom); data_b = 8'($urandom); last_b = 1'($urandom);
      @(posedge clk); #1;
      chk_zero(tag);
    end
    exp_q.delete();
    beat_pend = 1'b0;
    cur_ga    = 1'b0;
    cur_gb    = 1'b0;
    last_data = '0;
    idle_in();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    beat_pend = 1'b0; cur_ga = 1'b0; cur_gb = 1'b0; last_data = '0;
    idle_in();

    // 1: reset and idle
    do_reset("rst");
    idle_in(); cyc("idle0", 1'b0, 1'b0);
    idle_in(); cyc("idle1", 1'b0, 1'b0);

    // 2: single four-beat burst from A
    drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0); cyc("s_req", 1'b1, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0); cyc("s_b1", 1'b1, 1'b0);
    drive(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0); cyc("s_b2", 1'b1, 1'b0);
    drive(1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 1'b0); cyc("s_b3", 1'b1, 1'b0);
    drive(1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0); cyc("s_b4", 1'b0, 1'b0);
    idle_in(); cyc("s_end", 1'b0, 1'b0);

    // 3: contention round-robin A,A,B,B,A,A from a fresh reset
    do_reset("rst2");
    drive(1'b1, 8'h21, 1'b0, 1'b1, 8'h31, 1'b0); cyc("c_req", 1'b1, 1'b0);
    drive(1'b1, 8'h21, 1'b0, 1'b1, 8'h31, 1'b0); cyc("c_a1", 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b1, 8'h31, 1'b0); cyc("c_a2", 1'b0, 1'b1);
    drive(1'b1, 8'h23, 1'b0, 1'b1, 8'h31, 1'b0); cyc("c_b1", 1'b0, 1'b1);
    drive(1'b1, 8'h23, 1'b0, 1'b1, 8'h32, 1'b1); cyc("c_b2", 1'b1, 1'b0);
    drive(1'b1, 8'h23, 1'b0, 1'b1, 8'h33, 1'b0); cyc("c_a3", 1'b1, 1'b0);
    drive(1'b1, 8'h24, 1'b1, 1'b0, 8'h33, 1'b0); cyc("c_a4", 1'b0, 1'b0);
    idle_in(); cyc("c_end", 1'b0, 1'b0);

    // 4: forced release after 16 beats with B waiting
    drive(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0); cyc("f_req", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 8'h90, 1'b0);
      if (i < 15) cyc("f_beat", 1'b1, 1'b0);
      else        cyc("f_last", 1'b0, 1'b1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h91, 1'b1); cyc("f_b", 1'b0, 1'b0);
    idle_in(); cyc("f_end", 1'b0, 1'b0);

    // 5: abandon with B pending, then abandon with nobody pending
    drive(1'b1, 8'h51, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ab_req", 1'b1, 1'b0);
    drive(1'b1, 8'h51, 1'b0, 1'b1, 8'h61, 1'b0); cyc("ab_a1", 1'b1, 1'b0);
    drive(1'b1, 8'h52, 1'b0, 1'b1, 8'h61, 1'b0); cyc("ab_a2", 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0); cyc("ab_drop", 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1); cyc("ab_b1", 1'b0, 1'b0);
    drive(1'b1, 8'h53, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ab2_req", 1'b1, 1'b0);
    drive(1'b1, 8'h53, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ab2_a1", 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ab2_drop", 1'b0, 1'b0);
    idle_in(); cyc("ab2_idle", 1'b0, 1'b0);

    // 6: asynchronous reset during beat 3 of 5 (pointer currently favours B)
    drive(1'b1, 8'h71, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ar_req", 1'b1, 1'b0);
    drive(1'b1, 8'h71, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ar_b1", 1'b1, 1'b0);
    drive(1'b1, 8'h72, 1'b0, 1'b0, 8'h00, 1'b0); cyc("ar_b2", 1'b1, 1'b0);
    drive(1'b1, 8'h73, 1'b0, 1'b0, 8'h00, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_zero("ar_async");
    exp_q.delete();
    beat_pend = 1'b0; cur_ga = 1'b0; cur_gb = 1'b0; last_data = '0;
    @(posedge clk); #1;
    chk_zero("ar_hold");
    idle_in();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("ar_rel");
    drive(1'b1, 8'h81, 1'b0, 1'b1, 8'hA1, 1'b0); cyc("ar_cont", 1'b1, 1'b0);
    drive(1'b1, 8'h81, 1'b1, 1'b0, 8'hA1, 1'b0); cyc("ar_a1", 1'b0, 1'b0);
    idle_in(); cyc("ar_end", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
